// File: rtl/puf_stream_reader_if.sv
// UART byte-stream and RAM read-port bundle for the SRAM-PUF readout engine.
// master = readout engine side, slave = UART core / RAM macro side.
interface puf_stream_reader_if #(
  parameter int unsigned RAM_DATA_W = 16,
  parameter int unsigned RAM_ADDR_W = 13
);
  logic                  uart_rx_ready;
  logic [7:0]            uart_data_from_rx;
  logic                  uart_tx_ready;
  logic [7:0]            uart_data_to_tx;
  logic                  uart_tx_enable;
  logic [RAM_ADDR_W-1:0] ram_raddr;
  logic [RAM_DATA_W-1:0] ram_rdata;
  logic                  busy;
  logic                  done;

  modport master (
    input  uart_rx_ready, uart_data_from_rx, uart_tx_ready, ram_rdata,
    output uart_data_to_tx, uart_tx_enable, ram_raddr, busy, done
  );

  modport slave (
    output uart_rx_ready, uart_data_from_rx, uart_tx_ready, ram_rdata,
    input  uart_data_to_tx, uart_tx_enable, ram_raddr, busy, done
  );
endinterface

// File: rtl/puf_stream_reader.sv
// SRAM-PUF readout engine: on a start command, streams DUMP_BYTES bytes of RAM content
// (little-endian lanes) over UART TX, with mid-dump abort and optional XOR trailer byte.
module puf_stream_reader #(
  parameter int unsigned RAM_DATA_W    = 16,
  parameter int unsigned RAM_ADDR_W    = 13,
  parameter int unsigned RAM_RD_LAT    = 1,
  parameter int unsigned DUMP_BYTES    = 16384,
  parameter logic [7:0]  CMD_START     = 8'h53,
  parameter logic [7:0]  CMD_ABORT     = 8'h78,
  parameter bit          SEND_CHECKSUM = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  puf_stream_reader_if.master bus
);

  localparam int unsigned BPW    = RAM_DATA_W / 8;
  localparam int unsigned LANE_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int unsigned IDX_W  = $clog2(DUMP_BYTES) + 1;

  typedef enum logic [3:0] {
    StInit, StInitWait, StIdle, StAddr, StMemWait, StLatch,
    StSend, StTxWait, StNext, StCkSend, StCkWait
  } state_e;

  state_e                state_q;
  logic [IDX_W-1:0]      idx_q;
  logic [LANE_W-1:0]     lane_q;
  logic [RAM_ADDR_W-1:0] word_q;
  logic [RAM_ADDR_W-1:0] raddr_q;
  logic [1:0]            lat_q;
  logic [7:0]            checksum_q;
  logic [7:0]            data_q;
  logic                  tx_en_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  abort_q;
  logic                  seen_low_q;

  logic [7:0] lane_byte;
  logic       abort_cmd;
  logic       abort_now;
  logic       tx_done;

  always_comb begin
    lane_byte = 8'h00;
    for (int k = 0; k < BPW; k++) begin
      if (lane_q == LANE_W'(k)) lane_byte = bus.ram_rdata[k*8 +: 8];
    end
  end

  // busy_q is high exactly in the dump states, so it also gates abort detection.
  assign abort_cmd = busy_q && bus.uart_rx_ready && (bus.uart_data_from_rx == CMD_ABORT);
  assign abort_now = abort_q || abort_cmd;
  // A byte is finished once the transmitter has gone busy and then idle again.
  assign tx_done   = seen_low_q && bus.uart_tx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StInit;
      idx_q      <= '0;
      lane_q     <= '0;
      word_q     <= '0;
      raddr_q    <= '0;
      lat_q      <= '0;
      checksum_q <= 8'h00;
      data_q     <= 8'h00;
      tx_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
      seen_low_q <= 1'b0;
    end else begin
      tx_en_q <= 1'b0;
      done_q  <= 1'b0;
      if (abort_cmd) abort_q <= 1'b1;
      if (!bus.uart_tx_ready) seen_low_q <= 1'b1;

      unique case (state_q)
        StInit: begin
          data_q <= 8'h00;
          if (bus.uart_tx_ready) begin
            tx_en_q    <= 1'b1;
            seen_low_q <= 1'b0;
            state_q    <= StInitWait;
          end
        end
        StInitWait: begin
          if (tx_done) state_q <= StIdle;
        end
        StIdle: begin
          if (bus.uart_rx_ready && (bus.uart_data_from_rx == CMD_START)) begin
            idx_q      <= '0;
            lane_q     <= '0;
            word_q     <= '0;
            checksum_q <= 8'h00;
            abort_q    <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= StAddr;
          end
        end
        StAddr: begin
          raddr_q <= word_q;
          lat_q   <= '0;
          state_q <= StMemWait;
        end
        StMemWait: begin
          if (lat_q == 2'(RAM_RD_LAT - 1)) state_q <= StLatch;
          else lat_q <= lat_q + 2'd1;
        end
        StLatch: begin
          data_q     <= lane_byte;
          checksum_q <= checksum_q ^ lane_byte;
          state_q    <= StSend;
        end
        StSend: begin
          if (bus.uart_tx_ready) begin
            tx_en_q    <= 1'b1;
            seen_low_q <= 1'b0;
            state_q    <= StTxWait;
          end
        end
        StTxWait: begin
          if (tx_done) state_q <= StNext;
        end
        StNext: begin
          if (abort_now) begin
            abort_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else if (idx_q == IDX_W'(DUMP_BYTES - 1)) begin
            if (SEND_CHECKSUM) begin
              state_q <= StCkSend;
            end else begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StIdle;
            end
          end else begin
            idx_q <= idx_q + IDX_W'(1);
            if (lane_q == LANE_W'(BPW - 1)) begin
              lane_q  <= '0;
              word_q  <= word_q + RAM_ADDR_W'(1);
              state_q <= StAddr;
            end else begin
              lane_q  <= lane_q + LANE_W'(1);
              state_q <= StLatch;
            end
          end
        end
        StCkSend: begin
          data_q <= checksum_q;
          if (bus.uart_tx_ready) begin
            tx_en_q    <= 1'b1;
            seen_low_q <= 1'b0;
            state_q    <= StCkWait;
          end
        end
        StCkWait: begin
          if (tx_done) begin
            busy_q  <= 1'b0;
            done_q  <= !abort_now;
            abort_q <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StInit;
      endcase
    end
  end

  assign bus.uart_data_to_tx = data_q;
  assign bus.uart_tx_enable  = tx_en_q;
  assign bus.ram_raddr       = raddr_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;

endmodule

// File: tb/tb_puf_stream_reader.sv
// Bench for puf_stream_reader: two instances (16-bit/lat 1/4 bytes/trailer and
// 32-bit/lat 3/8 bytes/no trailer) driven with directed commands against a byte-queue model.
module tb_puf_stream_reader;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  puf_stream_reader_if #(.RAM_DATA_W(16), .RAM_ADDR_W(4)) ifa ();
  puf_stream_reader_if #(.RAM_DATA_W(32), .RAM_ADDR_W(4)) ifb ();

  puf_stream_reader #(
    .RAM_DATA_W(16), .RAM_ADDR_W(4), .RAM_RD_LAT(1), .DUMP_BYTES(4),
    .CMD_START(8'h53), .CMD_ABORT(8'h78), .SEND_CHECKSUM(1'b1)
  ) dut_a (
    .clk(clk),
    .rst(rst_a),
    .bus(ifa)
  );

  puf_stream_reader #(
    .RAM_DATA_W(32), .RAM_ADDR_W(4), .RAM_RD_LAT(3), .DUMP_BYTES(8),
    .CMD_START(8'h53), .CMD_ABORT(8'h78), .SEND_CHECKSUM(1'b0)
  ) dut_b (
    .clk(clk),
    .rst(rst_b),
    .bus(ifb)
  );

  // RAM contents and read pipelines (A: 1 cycle, B: 3 cycles)
  logic [15:0] mem_a [16];
  logic [31:0] mem_b [16];
  logic [31:0] pb1, pb2;
  always @(posedge clk) begin
    ifa.ram_rdata <= mem_a[ifa.ram_raddr];
    pb1           <= mem_b[ifb.ram_raddr];
    pb2           <= pb1;
    ifb.ram_rdata <= pb2;
  end

  // UART transmitter models: go busy on enable, idle again after a few cycles
  logic txr_a = 1'b1, txr_b = 1'b1;
  int   tc_a = 0, tc_b = 0;
  assign ifa.uart_tx_ready = txr_a;
  assign ifb.uart_tx_ready = txr_b;
  always @(posedge clk) begin
    if (ifa.uart_tx_enable) begin txr_a <= 1'b0; tc_a <= 3; end
    else if (!txr_a) begin if (tc_a == 0) txr_a <= 1'b1; else tc_a <= tc_a - 1; end
    if (ifb.uart_tx_enable) begin txr_b <= 1'b0; tc_b <= 4; end
    else if (!txr_b) begin if (tc_b == 0) txr_b <= 1'b1; else tc_b <= tc_b - 1; end
  end

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] addr;
    logic       has_addr;
  } exp_t;

  exp_t       exp_a[$], exp_b[$];
  logic [7:0] log_a[$], log_b[$];
  int         txcnt[2];
  int         donecnt[2];
  int         vectors = 0;
  int         miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  function automatic logic [31:0] obs(input bit sel, input int what);
    case (what)
      0:       return sel ? 32'(ifb.uart_data_to_tx) : 32'(ifa.uart_data_to_tx);
      1:       return sel ? 32'(ifb.uart_tx_enable)  : 32'(ifa.uart_tx_enable);
      2:       return sel ? 32'(ifb.ram_raddr)       : 32'(ifa.ram_raddr);
      3:       return sel ? 32'(ifb.busy)            : 32'(ifa.busy);
      4:       return sel ? 32'(ifb.done)            : 32'(ifa.done);
      default: return sel ? 32'(ifb.uart_tx_ready)   : 32'(ifa.uart_tx_ready);
    endcase
  endfunction

  function automatic int qsize(input bit sel);
    return sel ? exp_b.size() : exp_a.size();
  endfunction

  // Spec-level model: byte i is lane i%BPW of word i/BPW, lane 0 in the low byte.
  function automatic logic [7:0] model_byte(input bit sel, input int i);
    if (!sel) return 8'(mem_a[i / 2] >> (8 * (i % 2)));
    return 8'(mem_b[i / 4] >> (8 * (i % 4)));
  endfunction

  task automatic push_exp(input bit sel, input exp_t e);
    if (sel) exp_b.push_back(e);
    else exp_a.push_back(e);
  endtask

  // Queue the first n bytes of a dump; the trailer only if the whole dump goes out.
  task automatic push_dump(input bit sel, input int n, input int total, input bit trailer);
    logic [7:0] ck = 8'h00;
    int bpw = sel ? 4 : 2;
    for (int i = 0; i < total; i++) begin
      ck = ck ^ model_byte(sel, i);
      if (i < n) push_exp(sel, '{data: model_byte(sel, i), addr: 4'(i / bpw), has_addr: 1'b1});
    end
    if (trailer) push_exp(sel, '{data: ck, addr: 4'h0, has_addr: 1'b0});
  endtask

  task automatic tx_event(input bit sel);
    exp_t e;
    txcnt[sel]++;
    chk($sformatf("tx_ready_at_enable[%0d]", sel), obs(sel, 5), 32'd1);
    if (qsize(sel) == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_tx[%0d]: got byte %0h, expected no transmit", sel, obs(sel, 0));
    end else begin
      e = sel ? exp_b.pop_front() : exp_a.pop_front();
      chk($sformatf("tx_data[%0d]", sel), obs(sel, 0), 32'(e.data));
      if (e.has_addr) chk($sformatf("tx_raddr[%0d]", sel), obs(sel, 2), 32'(e.addr));
    end
    if (sel) log_b.push_back(ifb.uart_data_to_tx);
    else log_a.push_back(ifa.uart_data_to_tx);
  endtask

  // Single compare process against the expected-byte queues.
  always @(negedge clk) begin
    if (ifa.uart_tx_enable === 1'b1) tx_event(1'b0);
    if (ifb.uart_tx_enable === 1'b1) tx_event(1'b1);
    if (ifa.done === 1'b1) donecnt[0]++;
    if (ifb.done === 1'b1) donecnt[1]++;
  end

  task automatic send_cmd(input bit sel, input logic [7:0] b);
    @(negedge clk);
    if (sel) begin ifb.uart_rx_ready = 1'b1; ifb.uart_data_from_rx = b; end
    else begin ifa.uart_rx_ready = 1'b1; ifa.uart_data_from_rx = b; end
    @(negedge clk);
    ifa.uart_rx_ready = 1'b0;
    ifb.uart_rx_ready = 1'b0;
  endtask

  task automatic wait_quiet(input bit sel, input string name);
    int n = 0;
    while (!(qsize(sel) == 0 && obs(sel, 3) == 0 && obs(sel, 5) == 1) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: %0d bytes outstanding, busy=%0d", name, qsize(sel), obs(sel, 3));
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic wait_tx(input bit sel, input int target, input string name);
    int n = 0;
    while (txcnt[sel] < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: %0d transmits, expected %0d", name, txcnt[sel], target);
    end
  endtask

  // want holds the bytes left to right from the top of the 64-bit literal
  task automatic chk_log(input bit sel, input string name, input int n, input logic [63:0] want);
    int sz = sel ? log_b.size() : log_a.size();
    chk({name, "_len"}, 32'(sz), 32'(n));
    for (int k = 0; k < n && k < sz; k++) begin
      chk($sformatf("%s_byte%0d", name, k), sel ? 32'(log_b[k]) : 32'(log_a[k]),
          32'(want[63 - 8*k -: 8]));
    end
  endtask

  task automatic chk_reset(input bit sel, input string name);
    for (int w = 0; w < 5; w++) chk($sformatf("%s_out%0d", name, w), obs(sel, w), 32'd0);
  endtask

  int base;

  initial begin
    ifa.uart_rx_ready = 1'b0; ifa.uart_data_from_rx = 8'h00;
    ifb.uart_rx_ready = 1'b0; ifb.uart_data_from_rx = 8'h00;
    for (int k = 0; k < 16; k++) begin
      mem_a[k] = 16'(k * 16'h1111);
      mem_b[k] = 32'(k * 32'h01010101);
    end
    mem_a[0] = 16'hA55A; mem_a[1] = 16'h1234;
    mem_b[0] = 32'hDDCCBBAA; mem_b[1] = 32'h44332211;
    txcnt = '{0, 0};
    donecnt = '{0, 0};

    // T1: reset values, then one dummy 00 byte per instance
    repeat (3) @(negedge clk);
    chk_reset(1'b0, "t1_reset_a");
    chk_reset(1'b1, "t1_reset_b");
    push_exp(1'b0, '{data: 8'h00, addr: 4'h0, has_addr: 1'b0});
    push_exp(1'b1, '{data: 8'h00, addr: 4'h0, has_addr: 1'b0});
    rst_a = 1'b0; rst_b = 1'b0;
    wait_quiet(1'b0, "t1_a");
    wait_quiet(1'b1, "t1_b");
    chk_log(1'b0, "t1_log_a", 1, 64'h00);
    chk("t1_tx_count_b", 32'(txcnt[1]), 32'd1);

    // T2: A dumps 5A A5 34 12 plus trailer 5A^A5^34^12 = D9
    log_a.delete();
    base = donecnt[0];
    push_dump(1'b0, 4, 4, 1'b1);
    send_cmd(1'b0, 8'h53);
    chk("t2_busy", obs(1'b0, 3), 32'd1);
    wait_quiet(1'b0, "t2");
    chk("t2_done_once", 32'(donecnt[0] - base), 32'd1);
    chk_log(1'b0, "t2_log", 5, 64'h5AA53412D9000000);

    // T3: B dumps 8 bytes little-endian across two words, no trailer
    log_b.delete();
    base = donecnt[1];
    push_dump(1'b1, 8, 8, 1'b0);
    send_cmd(1'b1, 8'h53);
    chk("t3_busy", obs(1'b1, 3), 32'd1);
    wait_quiet(1'b1, "t3");
    chk("t3_done_once", 32'(donecnt[1] - base), 32'd1);
    chk_log(1'b1, "t3_log", 8, 64'hAABBCCDD11223344);

    // T4: abort during 3rd byte on B, then a full restart
    base = donecnt[1];
    push_dump(1'b1, 3, 8, 1'b0);
    send_cmd(1'b1, 8'h53);
    wait_tx(1'b1, txcnt[1] + 3, "t4_b");
    send_cmd(1'b1, 8'h78);
    wait_quiet(1'b1, "t4_abort_b");
    chk("t4_no_done_b", 32'(donecnt[1] - base), 32'd0);
    push_dump(1'b1, 8, 8, 1'b0);
    send_cmd(1'b1, 8'h53);
    wait_quiet(1'b1, "t4_restart_b");
    chk("t4_restart_done_b", 32'(donecnt[1] - base), 32'd1);

    // T4 on A: abort during 2nd byte, restart must recompute the trailer from zero
    base = donecnt[0];
    push_dump(1'b0, 2, 4, 1'b0);
    send_cmd(1'b0, 8'h53);
    wait_tx(1'b0, txcnt[0] + 2, "t4_a");
    send_cmd(1'b0, 8'h78);
    wait_quiet(1'b0, "t4_abort_a");
    chk("t4_no_done_a", 32'(donecnt[0] - base), 32'd0);
    log_a.delete();
    push_dump(1'b0, 4, 4, 1'b1);
    send_cmd(1'b0, 8'h53);
    wait_quiet(1'b0, "t4_restart_a");
    chk("t4_restart_done_a", 32'(donecnt[0] - base), 32'd1);
    chk_log(1'b0, "t4_restart_log", 5, 64'h5AA53412D9000000);

    // Abort while the trailer is in flight: trailer still goes out, done suppressed
    base = donecnt[0];
    push_dump(1'b0, 4, 4, 1'b1);
    send_cmd(1'b0, 8'h53);
    wait_tx(1'b0, txcnt[0] + 5, "trailer_abort");
    send_cmd(1'b0, 8'h78);
    wait_quiet(1'b0, "trailer_abort");
    chk("trailer_abort_no_done", 32'(donecnt[0] - base), 32'd0);

    // T5: reset in TX_WAIT of the 3rd byte (word 1), dummy byte must follow
    log_a.delete();
    base = donecnt[0];
    push_dump(1'b0, 3, 4, 1'b0);
    send_cmd(1'b0, 8'h53);
    wait_tx(1'b0, txcnt[0] + 3, "t5");
    @(negedge clk);
    rst_a = 1'b1;
    push_exp(1'b0, '{data: 8'h00, addr: 4'h0, has_addr: 1'b0});
    @(negedge clk);
    chk_reset(1'b0, "t5_reset");
    rst_a = 1'b0;
    wait_quiet(1'b0, "t5_init");
    chk("t5_no_done", 32'(donecnt[0] - base), 32'd0);
    chk_log(1'b0, "t5_log", 4, 64'h5AA5340000000000);

    // T6: 'S' during a dump and 'x' in IDLE are both ignored
    base = donecnt[0];
    push_dump(1'b0, 4, 4, 1'b1);
    send_cmd(1'b0, 8'h53);
    wait_tx(1'b0, txcnt[0] + 2, "t6");
    send_cmd(1'b0, 8'h53);
    wait_quiet(1'b0, "t6_dump");
    chk("t6_done_once", 32'(donecnt[0] - base), 32'd1);
    base = txcnt[0];
    send_cmd(1'b0, 8'h78);
    repeat (10) @(negedge clk);
    chk("t6_idle_abort_no_tx", 32'(txcnt[0] - base), 32'd0);
    chk("t6_idle_abort_busy", obs(1'b0, 3), 32'd0);
    base = donecnt[0];
    push_dump(1'b0, 4, 4, 1'b1);
    send_cmd(1'b0, 8'h53);
    wait_quiet(1'b0, "t6_after");
    chk("t6_after_done", 32'(donecnt[0] - base), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
